// File: rtl/ddr4_mc_act_throttle.sv
// DDR4 activate throttle: per-rank tRRD_L / tRRD_S / tFAW tracking that qualifies per-port ACT requests.
// Optional macro ACT_THROTTLE_STATS_EN adds the 16-bit saturating blocked-cycle counter output blkCnt.
module ddr4_mc_act_throttle #(
   parameter int unsigned NPORT       = 4,
   parameter int unsigned NRANK       = 4,
   parameter int unsigned RKBITS      = 2,
   parameter int unsigned tRRD_L      = 6,
   parameter int unsigned tRRD_S      = 4,
   parameter int unsigned tFAW        = 20,
   parameter int unsigned FAW_ACTS    = 4,
   parameter int unsigned PAIR_GROUPS = 0,
   parameter real         TCQ         = 0.1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [NPORT-1:0]        actReq,
   input  logic [NPORT*RKBITS-1:0] cmdRank,
   input  logic [NPORT-1:0]        winPort,
   input  logic [RKBITS-1:0]       winRank,
`ifdef ACT_THROTTLE_STATS_EN
   output logic [15:0]             blkCnt,
`endif
   output logic [NPORT-1:0]        actReqT
);

   localparam int unsigned NGRP  = (PAIR_GROUPS != 0) ? (NPORT + 1) / 2 : NPORT;
   localparam int unsigned GW    = (NGRP > 1) ? $clog2(NGRP) : 1;
   localparam int unsigned PW    = $clog2(NPORT);
   localparam int unsigned RSPAN = 1 << RKBITS;
   localparam int unsigned LW    = $clog2(tRRD_L + 1);
   localparam int unsigned SW    = $clog2(tRRD_S + 1);
   localparam int unsigned FW    = $clog2(tFAW + 1);
   localparam int unsigned SLW   = (FAW_ACTS > 1) ? $clog2(FAW_ACTS) : 1;
   localparam int unsigned CW    = $clog2(FAW_ACTS + 1);
   // Rank indices at or above NRANK are untracked; their state stays zero.
   localparam logic [RSPAN-1:0] RANK_MASK = RSPAN'((64'd1 << NRANK) - 64'd1);

   if (NPORT < 2 || NPORT > 8) begin : g_chk_nport
      $error("ddr4_mc_act_throttle: NPORT must be 2..8");
   end
   if (NRANK < 1 || NRANK > 8 || (NRANK & (NRANK - 1)) != 0) begin : g_chk_nrank
      $error("ddr4_mc_act_throttle: NRANK must be a power of two in 1..8");
   end
   if (RKBITS != ((NRANK > 1) ? $clog2(NRANK) : 1)) begin : g_chk_rkbits
      $error("ddr4_mc_act_throttle: RKBITS must equal max(1, clog2(NRANK))");
   end
   if (tRRD_L < 1 || tRRD_L > 63 || tRRD_S < 1 || tRRD_S > tRRD_L) begin : g_chk_rrd
      $error("ddr4_mc_act_throttle: need 1 <= tRRD_S <= tRRD_L <= 63");
   end
   if (tFAW < 1 || tFAW > 255 || FAW_ACTS < 1 || FAW_ACTS > 8) begin : g_chk_faw
      $error("ddr4_mc_act_throttle: tFAW must be 1..255 and FAW_ACTS 1..8");
   end
   if (PAIR_GROUPS > 1 || TCQ < 0.0) begin : g_chk_misc
      $error("ddr4_mc_act_throttle: PAIR_GROUPS must be 0/1 and TCQ non-negative");
   end

   function automatic logic [GW-1:0] grp_of(input int unsigned p);
      return (PAIR_GROUPS != 0) ? GW'(p >> 1) : GW'(p);
   endfunction

   logic [LW-1:0]     r_rrdl [RSPAN][NGRP];
   logic [SW-1:0]     r_rrds [RSPAN];
   logic [FW-1:0]     r_faw  [RSPAN][FAW_ACTS];

   logic              w_win_vld;
   logic [PW-1:0]     w_win_port;
   logic [GW-1:0]     w_win_grp;
   logic              w_act;
   logic [SLW-1:0]    w_slot;
   logic [FW-1:0]     w_slot_min;
   logic [CW-1:0]     w_faw_busy [RSPAN];
   logic [RSPAN-1:0]  w_faw_ok;
   logic [RKBITS-1:0] w_rank [NPORT];
   logic [NPORT-1:0]  w_rrd_ok;

   // Issued ACT decode: lowest set winPort bit wins, out-of-range ranks are dropped.
   always_comb begin
      w_win_vld  = 1'b0;
      w_win_port = '0;
      for (int p = NPORT - 1; p >= 0; p--) begin
         if (winPort[p]) begin
            w_win_vld  = 1'b1;
            w_win_port = PW'(p);
         end
      end
      w_win_grp = grp_of(32'(w_win_port));
      w_act     = !rst && w_win_vld && RANK_MASK[winRank];
   end

   // Smallest-count slot with lowest-index tie-break is the lowest idle slot whenever one exists.
   always_comb begin
      w_slot     = '0;
      w_slot_min = r_faw[winRank][0];
      for (int s = 1; s < FAW_ACTS; s++) begin
         if (r_faw[winRank][s] < w_slot_min) begin
            w_slot     = SLW'(s);
            w_slot_min = r_faw[winRank][s];
         end
      end
   end

   always_ff @(posedge clk) begin
      for (int r = 0; r < RSPAN; r++) begin
         if (rst) begin
            r_rrds[r] <= '0;
            for (int g = 0; g < NGRP; g++) r_rrdl[r][g] <= '0;
            for (int s = 0; s < FAW_ACTS; s++) r_faw[r][s] <= '0;
         end else begin
            if (w_act && winRank == RKBITS'(r)) begin
               r_rrds[r] <= SW'(tRRD_S - 1);
            end else if (r_rrds[r] != '0) begin
               r_rrds[r] <= r_rrds[r] - SW'(1);
            end
            for (int g = 0; g < NGRP; g++) begin
               if (w_act && winRank == RKBITS'(r) && w_win_grp == GW'(g)) begin
                  r_rrdl[r][g] <= LW'(tRRD_L - 1);
               end else if (r_rrdl[r][g] != '0) begin
                  r_rrdl[r][g] <= r_rrdl[r][g] - LW'(1);
               end
            end
            for (int s = 0; s < FAW_ACTS; s++) begin
               if (w_act && winRank == RKBITS'(r) && w_slot == SLW'(s)) begin
                  r_faw[r][s] <= FW'(tFAW - 1);
               end else if (r_faw[r][s] != '0) begin
                  r_faw[r][s] <= r_faw[r][s] - FW'(1);
               end
            end
         end
      end
   end

   // A rank is FAW-open while fewer than FAW_ACTS of its slots are still counting.
   always_comb begin
      for (int r = 0; r < RSPAN; r++) begin
         w_faw_busy[r] = '0;
         for (int s = 0; s < FAW_ACTS; s++) begin
            if (r_faw[r][s] != '0) w_faw_busy[r] = w_faw_busy[r] + CW'(1);
         end
         w_faw_ok[r] = (w_faw_busy[r] < CW'(FAW_ACTS));
      end
   end

   // Reset bypasses the throttle so requests pass straight through.
   always_comb begin
      for (int p = 0; p < NPORT; p++) begin
         w_rank[p]   = cmdRank[p*RKBITS +: RKBITS];
         w_rrd_ok[p] = (r_rrdl[w_rank[p]][grp_of(p)] == '0) && (r_rrds[w_rank[p]] == '0);
         actReqT[p]  = rst ? actReq[p] : (actReq[p] & w_rrd_ok[p] & w_faw_ok[w_rank[p]]);
      end
   end

`ifdef ACT_THROTTLE_STATS_EN
   logic [15:0] r_blk_cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_blk_cnt <= '0;
      end else if (|(actReq & ~actReqT) && r_blk_cnt != 16'hFFFF) begin
         r_blk_cnt <= r_blk_cnt + 16'd1;
      end
   end

   assign blkCnt = r_blk_cnt;
`endif

endmodule

// File: tb/tb_ddr4_mc_act_throttle.sv
// Bench for ddr4_mc_act_throttle: directed timing scenarios plus randomized traffic against a timestamp model.
module tb_ddr4_mc_act_throttle;
   localparam int NPORT    = 4;
   localparam int NRANK    = 4;
   localparam int RKBITS   = 2;
   localparam int TRRD_L   = 6;
   localparam int TRRD_S   = 4;
   localparam int TFAW     = 20;
   localparam int FAW_ACTS = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic                    rst;
   logic [NPORT-1:0]        actReq, winPort, actReqT;
   logic [NPORT*RKBITS-1:0] cmdRank;
   logic [RKBITS-1:0]       winRank;
   logic [NPORT-1:0]        p_actReq, p_winPort, p_actReqT;
   logic [NPORT*RKBITS-1:0] p_cmdRank;
   logic [RKBITS-1:0]       p_winRank;
`ifdef ACT_THROTTLE_STATS_EN
   logic [15:0]             blkCnt, p_blkCnt;
   int                      exp_blk;
`endif

   int n_checks = 0;
   int n_pass   = 0;
   int cyc      = 0;

   ddr4_mc_act_throttle #(
      .NPORT(NPORT), .NRANK(NRANK), .RKBITS(RKBITS), .tRRD_L(TRRD_L), .tRRD_S(TRRD_S),
      .tFAW(TFAW), .FAW_ACTS(FAW_ACTS), .PAIR_GROUPS(0), .TCQ(0.1)
   ) u_dut (
      .clk(clk), .rst(rst), .actReq(actReq), .cmdRank(cmdRank), .winPort(winPort), .winRank(winRank),
`ifdef ACT_THROTTLE_STATS_EN
      .blkCnt(blkCnt),
`endif
      .actReqT(actReqT)
   );

   ddr4_mc_act_throttle #(
      .NPORT(NPORT), .NRANK(NRANK), .RKBITS(RKBITS), .tRRD_L(TRRD_L), .tRRD_S(TRRD_S),
      .tFAW(TFAW), .FAW_ACTS(FAW_ACTS), .PAIR_GROUPS(1), .TCQ(0.1)
   ) u_dut_pair (
      .clk(clk), .rst(rst), .actReq(p_actReq), .cmdRank(p_cmdRank), .winPort(p_winPort),
      .winRank(p_winRank),
`ifdef ACT_THROTTLE_STATS_EN
      .blkCnt(p_blkCnt),
`endif
      .actReqT(p_actReqT)
   );

   // Reference model: time of last ACT per rank, per (rank, port), and the FAW_ACTS most recent per rank.
   int last_any [NRANK];
   int last_grp [NRANK][NPORT];
   int faw_t    [NRANK][FAW_ACTS];

   task automatic model_clear();
      for (int r = 0; r < NRANK; r++) begin
         last_any[r] = -100000;
         for (int p = 0; p < NPORT; p++) last_grp[r][p] = -100000;
         for (int s = 0; s < FAW_ACTS; s++) faw_t[r][s] = -100000;
      end
   endtask

   function automatic bit model_ok(int p, int r);
      return (cyc - last_any[r] >= TRRD_S) && (cyc - last_grp[r][p] >= TRRD_L) &&
             (cyc - faw_t[r][FAW_ACTS-1] >= TFAW);
   endfunction

   task automatic model_act(int p, int r);
      last_any[r]    = cyc;
      last_grp[r][p] = cyc;
      for (int s = FAW_ACTS - 1; s > 0; s--) faw_t[r][s] = faw_t[r][s-1];
      faw_t[r][0] = cyc;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic idle();
      actReq = '0; cmdRank = '0; winPort = '0; winRank = '0;
      p_actReq = '0; p_cmdRank = '0; p_winPort = '0; p_winRank = '0;
   endtask

   task automatic do_reset();
      tick();
      rst = 1'b1;
      idle();
      tick();
      model_clear();
   endtask

   task automatic test_reset();
      rst = 1'b1;
      for (int k = 0; k < 8; k++) begin
         tick();
         actReq  = NPORT'($urandom);  cmdRank  = 8'($urandom);
         winPort = NPORT'($urandom);  winRank  = RKBITS'($urandom);
         p_actReq = NPORT'($urandom); p_cmdRank = 8'($urandom);
         p_winPort = NPORT'($urandom); p_winRank = RKBITS'($urandom);
         #1;
         n_checks++;
         if (actReqT !== actReq || p_actReqT !== p_actReq)
            $display("FAIL reset_follow k=%0d actReqT=%b/%b expected %b/%b", k, actReqT, p_actReqT,
                     actReq, p_actReq);
         else n_pass++;
      end
      tick();
      rst = 1'b0;
      actReq = '1; cmdRank = 8'($urandom); winPort = '0;
      p_actReq = '1; p_cmdRank = 8'($urandom); p_winPort = '0;
      #1;
      n_checks++;
      if (actReqT !== 4'b1111 || p_actReqT !== 4'b1111)
         $display("FAIL reset_state actReqT=%b/%b expected 1111/1111", actReqT, p_actReqT);
      else n_pass++;
`ifdef ACT_THROTTLE_STATS_EN
      n_checks++;
      if (blkCnt !== 16'd0) $display("FAIL reset_blkcnt blkCnt=%0d expected 0", blkCnt);
      else n_pass++;
`endif
   endtask

   task automatic test_rrd_l();
      logic [NPORT-1:0] e;
      do_reset();
      for (int k = 0; k <= 9; k++) begin
         tick();
         rst = 1'b0;
         idle();
         actReq  = 4'b0001;
         winPort = (k == 0) ? 4'b0001 : 4'b0000;
         e = (k == 0 || k >= TRRD_L) ? 4'b0001 : 4'b0000;
         #1;
         n_checks++;
         if (actReqT !== e) $display("FAIL rrd_l k=%0d actReqT=%b expected %b", k, actReqT, e);
         else n_pass++;
`ifdef ACT_THROTTLE_STATS_EN
         if (k == 6) begin
            n_checks++;
            if (blkCnt !== 16'd5) $display("FAIL blkcnt_rrd_l blkCnt=%0d expected 5", blkCnt);
            else n_pass++;
         end
`endif
      end
   endtask

   task automatic test_rrd_s();
      logic [NPORT-1:0] e;
      do_reset();
      for (int k = 0; k <= 6; k++) begin
         tick();
         rst = 1'b0;
         idle();
         if (k == 0) begin
            actReq = 4'b0001; winPort = 4'b0001; e = 4'b0001;
         end else begin
            // port1 -> rank0 (other group), port2 -> rank1 (other rank)
            actReq  = 4'b0110;
            cmdRank = 8'b00_01_00_00;
            e = 4'b0100 | ((k >= TRRD_S) ? 4'b0010 : 4'b0000);
         end
         #1;
         n_checks++;
         if (actReqT !== e) $display("FAIL rrd_s k=%0d actReqT=%b expected %b", k, actReqT, e);
         else n_pass++;
      end
   endtask

   task automatic test_faw();
      logic [NPORT-1:0] e;
      do_reset();
      for (int k = 0; k <= 22; k++) begin
         tick();
         rst = 1'b0;
         idle();
         if (k % 4 == 0 && k <= 12) begin
            actReq = NPORT'(1 << (k / 4)); cmdRank = 8'b10101010;
            winPort = actReq; winRank = 2'd2; e = actReq;
         end else if (k >= 13) begin
            // port0 -> rank2 (windowed), port1 -> rank3 (independent)
            actReq = 4'b0011; cmdRank = 8'b10101110;
            e = 4'b0010 | ((k >= TFAW) ? 4'b0001 : 4'b0000);
         end else begin
            e = 4'b0000;
         end
         #1;
         n_checks++;
         if (actReqT !== e) $display("FAIL faw k=%0d actReqT=%b expected %b", k, actReqT, e);
         else n_pass++;
      end
   endtask

   task automatic test_reset_mid();
      logic [NPORT-1:0] e;
      do_reset();
      for (int k = 0; k <= 16; k++) begin
         tick();
         idle();
         rst = (k == 12);
         if (k % 4 == 0 && k <= 12) begin
            actReq = NPORT'(1 << (k / 4)); cmdRank = 8'b10101010;
            winPort = actReq; winRank = 2'd2; e = actReq;
         end else if (k >= 13) begin
            actReq = 4'b1111; cmdRank = 8'b10101010; e = 4'b1111;
         end else begin
            e = 4'b0000;
         end
         #1;
         n_checks++;
         if (actReqT !== e) $display("FAIL reset_mid k=%0d actReqT=%b expected %b", k, actReqT, e);
         else n_pass++;
      end
   endtask

   task automatic test_pair();
      logic [NPORT-1:0] e;
      do_reset();
      for (int k = 0; k <= 8; k++) begin
         tick();
         rst = 1'b0;
         idle();
         if (k == 0) begin
            p_actReq = 4'b0001; p_winPort = 4'b0001; e = 4'b0001;
         end else begin
            // port1 shares group 0 with port0; port2 is group 1
            p_actReq = 4'b0110;
            e = ((k >= TRRD_L) ? 4'b0010 : 4'b0000) | ((k >= TRRD_S) ? 4'b0100 : 4'b0000);
         end
         #1;
         n_checks++;
         if (p_actReqT !== e) $display("FAIL pair k=%0d actReqT=%b expected %b", k, p_actReqT, e);
         else n_pass++;
      end
   endtask

   task automatic test_random();
      logic [NPORT-1:0] e;
      int start, w, q, hi;
      bit found;
      do_reset();
`ifdef ACT_THROTTLE_STATS_EN
      exp_blk = 0;
`endif
      for (int k = 0; k < 600; k++) begin
         tick();
         idle();
         rst     = ($urandom_range(0, 99) < 2);
         actReq  = NPORT'($urandom);
         cmdRank = 8'($urandom);
         e = '0;
         for (int p = 0; p < NPORT; p++)
            if (actReq[p]) e[p] = rst ? 1'b1 : model_ok(p, int'(cmdRank[p*RKBITS +: RKBITS]));
         winRank = RKBITS'($urandom_range(0, NRANK - 1));
         if ($urandom_range(0, 2) != 0 && e != '0) begin
            start = $urandom_range(0, NPORT - 1);
            found = 1'b0;
            w = 0;
            for (int j = 0; j < NPORT; j++) begin
               q = (start + j) % NPORT;
               if (e[q] && !found) begin found = 1'b1; w = q; end
            end
            hi = ((1 << NPORT) - 1) & ~((2 << w) - 1);
            winPort = NPORT'((1 << w) | (int'($urandom) & hi));
            winRank = cmdRank[w*RKBITS +: RKBITS];
         end
         #1;
         n_checks++;
         if (actReqT !== e)
            $display("FAIL random k=%0d rst=%b actReq=%b cmdRank=%b actReqT=%b expected %b",
                     k, rst, actReq, cmdRank, actReqT, e);
         else n_pass++;
`ifdef ACT_THROTTLE_STATS_EN
         n_checks++;
         if (blkCnt !== 16'(exp_blk))
            $display("FAIL random_blkcnt k=%0d blkCnt=%0d expected %0d", k, blkCnt, exp_blk);
         else n_pass++;
         if (rst) exp_blk = 0;
         else if ((actReq & ~e) != '0 && exp_blk < 65535) exp_blk++;
`endif
         if (rst) begin
            model_clear();
         end else if (winPort != '0) begin
            found = 1'b0;
            for (int p = 0; p < NPORT; p++) begin
               if (winPort[p] && !found) begin found = 1'b1; model_act(p, int'(winRank)); end
            end
         end
      end
   endtask

`ifdef ACT_THROTTLE_STATS_EN
   task automatic test_blk_sat();
      do_reset();
      for (int k = 0; k < 70000; k++) begin
         tick();
         rst = 1'b0;
         idle();
         actReq = 4'b0001; winPort = 4'b0001;
      end
      tick();
      idle();
      #1;
      n_checks++;
      if (blkCnt !== 16'hFFFF) $display("FAIL blkcnt_sat blkCnt=%0d expected 65535", blkCnt);
      else n_pass++;
   endtask
`endif

   initial begin
      rst = 1'b1;
      idle();
      model_clear();
      test_reset();
      test_rrd_l();
      test_rrd_s();
      test_faw();
      test_reset_mid();
      test_pair();
      test_random();
`ifdef ACT_THROTTLE_STATS_EN
      test_blk_sat();
`endif
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
